// File: rtl/comm_frame_rx_if.sv
// ---------------------------------------------------------------------------
// comm_frame_rx_if
//   Bundles the two handshakes of the frame assembler together with its
//   status pulses.
//   UART side     : rx_rdy, rx_data (byte in), clr_rx_rdy (consume strobe out)
//   Consumer side : cmd_rdy, cmd, data (frame out), clr_cmd_rdy (ack in)
//   Status        : frm_err (timeout drop pulse), ovrn (overrun pulse)
//   Modports:
//     slave  - the frame assembler itself
//     master - the environment (UART receiver + command consumer)
// ---------------------------------------------------------------------------
interface comm_frame_rx_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        frm_err;
  logic        ovrn;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    output clr_rx_rdy, cmd_rdy, cmd, data, frm_err, ovrn
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy,
    input  clr_rx_rdy, cmd_rdy, cmd, data, frm_err, ovrn
  );
endinterface

// File: rtl/comm_frame_rx.sv
// ---------------------------------------------------------------------------
// comm_frame_rx
//   Assembles three consecutive UART bytes (opcode, data high, data low) into
//   one command frame. A partial frame is discarded if the gap between two of
//   its bytes reaches TIMEOUT clocks, so a lost byte cannot shift the framing.
//
//   Parameters:
//     TIMEOUT - clocks allowed between bytes of one frame (>= 2)
//     TO_W    - timeout counter width, must hold TIMEOUT-1
//   Ports:
//     clk - system clock, rising edge
//     rst - asynchronous active-high reset
//     bus - comm_frame_rx_if.slave:
//             rx_rdy/rx_data in, clr_rx_rdy out (combinational = rx_rdy)
//             cmd_rdy/cmd/data out, clr_cmd_rdy in
//             frm_err, ovrn one-cycle status pulses out
// ---------------------------------------------------------------------------
module comm_frame_rx #(
  parameter int TIMEOUT = 65536,
  parameter int TO_W    = 17
) (
  input  logic            clk,
  input  logic            rst,
  comm_frame_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic [7:0]      op_sh, hi_sh;

  logic accept;
  logic cap_op;
  logic cap_hi;
  logic complete;
  logic timeout;

  // Every presented byte is taken in the cycle it is seen, whatever the state.
  assign accept         = bus.rx_rdy;
  assign bus.clr_rx_rdy = bus.rx_rdy;

  // -------------------------------------------------------------------------
  // Next-state / control decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_op    = 1'b0;
    cap_hi    = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          cap_op    = 1'b1;
          state_nxt = WAIT_HI;
        end
      end

      WAIT_HI: begin
        if (accept) begin
          // A byte in the timeout cycle still wins.
          cap_hi    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WAIT_LO;
        end else if (cnt >= TO_LAST) begin
          timeout   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt + TO_W'(1);
        end
      end

      WAIT_LO: begin
        if (accept) begin
          complete  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt >= TO_LAST) begin
          timeout   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt + TO_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and timeout counter
  // -------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Shadow bytes of the frame under assembly
  // -------------------------------------------------------------------------
  // NOTE: the shadows are plain registers, not a memory, and are reset so the
  // datapath starts from a known value after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sh <= 8'h00;
      hi_sh <= 8'h00;
    end else begin
      if (cap_op) op_sh <= bus.rx_data;
      if (cap_hi) hi_sh <= bus.rx_data;
    end
  end

  // -------------------------------------------------------------------------
  // Frame outputs and status pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cmd     <= 8'h00;
      bus.data    <= 16'h0000;
      bus.cmd_rdy <= 1'b0;
      bus.frm_err <= 1'b0;
      bus.ovrn    <= 1'b0;
    end else begin
      bus.frm_err <= timeout;
      // Overrun only when the consumer has not acknowledged in this cycle.
      bus.ovrn    <= complete & bus.cmd_rdy & ~bus.clr_cmd_rdy;
      if (complete) begin
        // Completion beats a same-cycle acknowledge.
        bus.cmd     <= op_sh;
        bus.data    <= {hi_sh, bus.rx_data};
        bus.cmd_rdy <= 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        bus.cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comm_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_comm_frame_rx
//   Directed bench for comm_frame_rx with TIMEOUT=100. Inputs change on the
//   falling edge; outputs are observed on the falling edge, i.e. half a cycle
//   after the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_comm_frame_rx;

  localparam int TIMEOUT = 100;

  logic clk;
  logic rst;

  comm_frame_rx_if bus ();

  comm_frame_rx #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (17)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one rising edge; called and returns on a
  // falling edge.
  task automatic drive_byte(input logic [7:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    #1;
    check("clr_rx_rdy", {31'd0, bus.clr_rx_rdy}, 32'd1);
    @(negedge clk);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drive_byte(a);
    drive_byte(b);
    drive_byte(c);
  endtask

  task automatic ack();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
  endtask

  // Watch for frm_err over n cycles; returns pulse count and first position.
  task automatic watch_frm_err(input int n, output int pulses, output int first_at);
    pulses   = 0;
    first_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.frm_err) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int first_at;

    rst             = 1'b1;
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = 8'h00;
    bus.clr_cmd_rdy = 1'b0;

    // Reset state
    idle(3);
    check("rst cmd_rdy",    {31'd0, bus.cmd_rdy},    32'd0);
    check("rst cmd",        {24'd0, bus.cmd},        32'h00);
    check("rst data",       {16'd0, bus.data},       32'h0000);
    check("rst frm_err",    {31'd0, bus.frm_err},    32'd0);
    check("rst ovrn",       {31'd0, bus.ovrn},       32'd0);
    check("rst clr_rx_rdy", {31'd0, bus.clr_rx_rdy}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Single frame, bytes spaced 60 clocks (inside the 100-clock window)
    drive_byte(8'h02); idle(59);
    drive_byte(8'h00); idle(59);
    drive_byte(8'h3A);
    check("f1 cmd",     {24'd0, bus.cmd},     32'h02);
    check("f1 data",    {16'd0, bus.data},    32'h003A);
    check("f1 cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    check("f1 ovrn",    {31'd0, bus.ovrn},    32'd0);
    ack();
    check("f1 ack cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    check("f1 ack cmd",     {24'd0, bus.cmd},     32'h02);
    check("f1 ack data",    {16'd0, bus.data},    32'h003A);

    drive_byte(8'h05); idle(40);
    drive_byte(8'h01); idle(40);
    drive_byte(8'hFF);
    check("f2 cmd",     {24'd0, bus.cmd},     32'h05);
    check("f2 data",    {16'd0, bus.data},    32'h01FF);
    check("f2 cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    ack();

    // Timeout: frm_err exactly 100 clocks after the last byte, exactly once
    drive_byte(8'h03); idle(10);
    drive_byte(8'h00);
    watch_frm_err(110, pulses, first_at);
    check("to pulses",   pulses,   32'd1);
    check("to position", first_at, 32'd100);
    check("to cmd hold", {24'd0, bus.cmd},     32'h05);
    check("to data hold", {16'd0, bus.data},   32'h01FF);
    check("to cmd_rdy",  {31'd0, bus.cmd_rdy}, 32'd0);
    frame(8'h04, 8'h00, 8'h3A);
    check("post-to cmd",  {24'd0, bus.cmd},  32'h04);
    check("post-to data", {16'd0, bus.data}, 32'h003A);
    ack();

    // Byte arriving when the counter sits at TIMEOUT-1 is accepted
    drive_byte(8'h09);
    idle(TIMEOUT - 1);
    drive_byte(8'h00);
    check("edge frm_err", {31'd0, bus.frm_err}, 32'd0);
    drive_byte(8'hAB);
    check("edge cmd",     {24'd0, bus.cmd},     32'h09);
    check("edge data",    {16'd0, bus.data},    32'h00AB);
    check("edge cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    ack();

    // Overrun: second frame lands while cmd_rdy is still set
    frame(8'h01, 8'h00, 8'h00);
    check("ov1 cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    check("ov1 ovrn",    {31'd0, bus.ovrn},    32'd0);
    idle(3);
    frame(8'h07, 8'h00, 8'h00);
    check("ov2 cmd",     {24'd0, bus.cmd},     32'h07);
    check("ov2 cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    check("ov2 ovrn",    {31'd0, bus.ovrn},    32'd1);
    idle(1);
    check("ov2 ovrn end", {31'd0, bus.ovrn},   32'd0);

    // Simultaneous completion and acknowledge with cmd_rdy already set:
    // set wins and, being acknowledged, it is not an overrun
    drive_byte(8'h08);
    drive_byte(8'h00);
    bus.rx_rdy      = 1'b1;
    bus.rx_data     = 8'h00;
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.rx_rdy      = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    check("sim cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
    check("sim cmd",     {24'd0, bus.cmd},     32'h08);
    check("sim ovrn",    {31'd0, bus.ovrn},    32'd0);
    ack();

    // Back-to-back bytes (clr_rx_rdy checked inside drive_byte)
    frame(8'h06, 8'h12, 8'h34);
    check("b2b cmd",     {24'd0, bus.cmd},     32'h06);
    check("b2b data",    {16'd0, bus.data},    32'h1234);
    check("b2b cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);

    // Reset mid-frame: outputs to reset values, partial frame lost silently
    drive_byte(8'h02);
    drive_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    check("mrst cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
    check("mrst cmd",     {24'd0, bus.cmd},     32'h00);
    check("mrst data",    {16'd0, bus.data},    32'h0000);
    check("mrst frm_err", {31'd0, bus.frm_err}, 32'd0);
    rst = 1'b0;
    watch_frm_err(110, pulses, first_at);
    check("mrst no frm_err", pulses, 32'd0);
    frame(8'h03, 8'h00, 8'h3A);
    check("mrst2 cmd",  {24'd0, bus.cmd},  32'h03);
    check("mrst2 data", {16'd0, bus.data}, 32'h003A);
    check("mrst2 ovrn", {31'd0, bus.ovrn}, 32'd0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
